// File: rtl/wasca_debug_ocimem.sv
// Debug monitor memory: JTAG/CPU shared monitor RAM with JTAG read-back and sticky drop-error flag.
// Optional macro WASCA_OCIMEM_CPU_WP_EN write-protects the upper RAM half against CPU writes.
module wasca_debug_ocimem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        J_RD = 2'd1,
        C_RD = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] MonAReg, addr_nx;
    logic              ready_nx, error_nx, mon_ld;
    logic              ram_re, ram_we;
    logic [ADDR_W-1:0] ram_raddr, ram_waddr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic [31:0]       rd_q;
    logic              cpu_wr_ok;
    logic              jtag_any;
    logic [ADDR_W-1:0] jdo_addr;
    logic              unused_jdo;
    logic [31:0]       mem [DEPTH];

    assign jdo_addr     = jdo[ADDR_W+17:18];
    assign jtag_any     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign avs_readdata = rd_q;
    assign unused_jdo   = ^jdo;

`ifdef WASCA_OCIMEM_CPU_WP_EN
    assign cpu_wr_ok = ~avs_address[ADDR_W-1];
`else
    assign cpu_wr_ok = 1'b1;
`endif

    // Next-state, RAM port steering and wait-request decode
    always_comb begin
        state_nx        = state;
        addr_nx         = MonAReg;
        ready_nx        = monitor_ready;
        error_nx        = monitor_error;
        mon_ld          = 1'b0;
        ram_re          = 1'b0;
        ram_raddr       = MonAReg;
        ram_we          = 1'b0;
        ram_be          = 4'h0;
        ram_waddr       = MonAReg;
        ram_wdata       = jdo[34:3];
        avs_waitrequest = 1'b1;

        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_nx  = jdo_addr;
                    ready_nx = 1'b0;
                    if (jdo[16]) error_nx = 1'b0;
                    // Lower-priority strobes in the same cycle are dropped
                    if (take_action_ocimem_b | take_no_action_ocimem_a) error_nx = 1'b1;
                    if (jdo[17]) begin
                        ram_re    = 1'b1;
                        ram_raddr = jdo_addr;
                        state_nx  = J_RD;
                    end
                end else if (take_action_ocimem_b) begin
                    ram_we   = 1'b1;
                    ram_be   = 4'hF;
                    addr_nx  = MonAReg + ADDR_W'(1);
                    ready_nx = 1'b0;
                    if (take_no_action_ocimem_a) error_nx = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    ram_re   = 1'b1;
                    state_nx = J_RD;
                end else if (avs_write) begin
                    avs_waitrequest = 1'b0;
                    ram_we          = cpu_wr_ok;
                    ram_be          = avs_byteenable;
                    ram_waddr       = avs_address;
                    ram_wdata       = avs_writedata;
                end else if (avs_read) begin
                    ram_re    = 1'b1;
                    ram_raddr = avs_address;
                    state_nx  = C_RD;
                end
            end
            J_RD: begin
                mon_ld   = 1'b1;
                ready_nx = 1'b1;
                addr_nx  = MonAReg + ADDR_W'(1);
                state_nx = IDLE;
                if (jtag_any) error_nx = 1'b1;
            end
            C_RD: begin
                avs_waitrequest = 1'b0;
                state_nx        = IDLE;
                if (jtag_any) error_nx = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        if (reset) avs_waitrequest = 1'b1;
    end

    // Control and data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            rd_q          <= '0;
        end else begin
            state         <= state_nx;
            MonAReg       <= addr_nx;
            monitor_ready <= ready_nx;
            monitor_error <= error_nx;
            if (mon_ld) MonDReg <= rd_q;
            if (ram_re) rd_q <= mem[ram_raddr];
        end
    end

    // Monitor RAM write port, byte-masked, contents not reset
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wasca_debug_ocimem.sv
// Directed self-checking bench for wasca_debug_ocimem (default ADDR_W = 8).
module tb_wasca_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int n_cmp = 0;
    int n_err = 0;

    wasca_debug_ocimem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd, input logic clr);
        return (38'(addr) << 18) | (38'(rd) << 17) | (38'(clr) << 16);
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        return 38'(data) << 3;
    endfunction

    task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b    = b;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be,
                             output int waits);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        waits          = 0;
        #1;
        while (avs_waitrequest && waits < 16) begin
            tick();
            waits++;
            #1;
        end
        tick();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] addr, output logic [31:0] data, output int waits);
        avs_address = addr;
        avs_read    = 1'b1;
        waits       = 0;
        #1;
        while (avs_waitrequest && waits < 16) begin
            tick();
            waits++;
            #1;
        end
        data = avs_readdata;
        tick();
        avs_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          w;
        int          hi;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b1;
        avs_writedata = '0;
        avs_byteenable = 4'hF;
        tick();
        tick();
        check("wait_in_reset", 32'(avs_waitrequest), 32'd1);
        avs_write = 1'b0;
        reset = 1'b0;
        tick();
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", 32'(monitor_ready), 32'd0);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_readdata", avs_readdata, 32'h0);
        check("idle_wait", 32'(avs_waitrequest), 32'd1);

        // CPU preload, then JTAG read with address load
        cpu_write(8'h10, 32'hDEADBEEF, 4'hF, w);
        check("cpu_wr_waits", 32'(w), 32'd0);
        cpu_write(8'h11, 32'h0BADF00D, 4'hF, w);
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h10, 1'b1, 1'b0));
        check("jrd_ready_n1", 32'(monitor_ready), 32'd0);
        tick();
        check("jrd_data", MonDReg, 32'hDEADBEEF);
        check("jrd_ready", 32'(monitor_ready), 32'd1);
        jtag(1'b0, 1'b1, 1'b0, '0);
        tick();
        check("jrd_incr_data", MonDReg, 32'h0BADF00D);
        check("spacing2_err", 32'(monitor_error), 32'd0);

        // Write burst wrapping through the top of the RAM
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'hFF, 1'b0, 1'b0));
        check("a_clr_ready", 32'(monitor_ready), 32'd0);
        tick();
        jtag(1'b0, 1'b0, 1'b1, mk_b(32'h11111111));
        tick();
        jtag(1'b0, 1'b0, 1'b1, mk_b(32'h22222222));
        tick();
        cpu_read(8'hFF, rd, w);
        check("wrap_ff", rd, 32'h11111111);
        check("cpu_rd_waits", 32'(w), 32'd1);
        cpu_read(8'h00, rd, w);
        check("wrap_00", rd, 32'h22222222);

        // CPU read contending with a JTAG read strobe
        cpu_write(8'h05, 32'h55AA55AA, 4'hF, w);
        avs_address = 8'h05;
        avs_read = 1'b1;
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        hi = 0;
        #1;
        while (avs_waitrequest && hi < 16) begin
            hi++;
            tick();
            take_no_action_ocimem_a = 1'b0;
            #1;
        end
        rd = avs_readdata;
        tick();
        avs_read = 1'b0;
        check("cont_wait_cycles", 32'(hi), 32'd3);
        check("cont_data", rd, 32'h55AA55AA);
        check("cont_error", 32'(monitor_error), 32'd0);

        // Strobe dropped in J_RD, then cleared
        tick();
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h20, 1'b1, 1'b0));
        jtag(1'b0, 1'b1, 1'b0, '0);
        check("drop_error", 32'(monitor_error), 32'd1);
        check("drop_ready", 32'(monitor_ready), 32'd1);
        tick();
        tick();
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h21, 1'b0, 1'b1));
        check("clear_error", 32'(monitor_error), 32'd0);
        tick();
        // Simultaneous strobes: only the highest is served
        jtag(1'b1, 1'b0, 1'b1, mk_a(8'h30, 1'b0, 1'b0));
        check("multi_error", 32'(monitor_error), 32'd1);
        tick();
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h00, 1'b0, 1'b1));
        check("clear_error2", 32'(monitor_error), 32'd0);
        tick();

        // Byte-enable masking
        cpu_write(8'h40, 32'h00000000, 4'hF, w);
        cpu_write(8'h40, 32'hAABBCCDD, 4'b0101, w);
        cpu_read(8'h40, rd, w);
        check("byteen", rd, 32'h00BB00DD);

        // Upper half: CPU protected only when the option is built in
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h80, 1'b0, 1'b0));
        tick();
        jtag(1'b0, 1'b0, 1'b1, mk_b(32'hA5A5A5A5));
        tick();
        cpu_write(8'h80, 32'h12345678, 4'hF, w);
        check("wp_wr_waits", 32'(w), 32'd0);
        cpu_read(8'h80, rd, w);
`ifdef WASCA_OCIMEM_CPU_WP_EN
        check("wp_cpu", rd, 32'hA5A5A5A5);
`else
        check("wp_cpu", rd, 32'h12345678);
`endif
        jtag(1'b1, 1'b0, 1'b0, mk_a(8'h80, 1'b0, 1'b0));
        tick();
        jtag(1'b0, 1'b0, 1'b1, mk_b(32'h5A5A5A5A));
        tick();
        cpu_read(8'h80, rd, w);
        check("wp_jtag", rd, 32'h5A5A5A5A);

        // Reset during J_RD aborts the read and returns the address to 0
        jtag(1'b0, 1'b1, 1'b0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("abort_ready", 32'(monitor_ready), 32'd0);
        check("abort_mondreg", MonDReg, 32'h0);
        check("abort_readdata", avs_readdata, 32'h0);
        jtag(1'b0, 1'b1, 1'b0, '0);
        tick();
        check("abort_addr0", MonDReg, 32'h22222222);
        check("abort_ready2", 32'(monitor_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
